// File: rtl/intra_recon_4x4.sv
// Intra 4x4 reconstruction: joins prediction and residual, adds and clips in a
// two-stage pipeline, and feeds the bottom row / right column back to the neighbour buffers.
module intra_recon_4x4 #(
  parameter int bitDepth = 8,
  parameter int RES_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bStop,
  input  logic [3:0]              gp_bitDepth,
  input  logic [2:0]              tuSize,
  input  logic                    pred_valid,
  output logic                    pred_ready,
  input  logic [bitDepth*16-1:0]  predSamples,
  input  logic [2:0]              X,
  input  logic [2:0]              Y,
  input  logic                    pred_last,
  input  logic                    res_bypass,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic [RES_W*16-1:0]     residual,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [bitDepth*16-1:0]  recSamples,
  output logic [2:0]              rec_X,
  output logic [2:0]              rec_Y,
  output logic                    rec_last,
  output logic                    tu_done,
  output logic                    nb_row_we,
  output logic [2:0]              nb_row_idx,
  output logic [bitDepth*4-1:0]   nb_row_data,
  output logic                    nb_col_we,
  output logic [2:0]              nb_col_idx,
  output logic [bitDepth*4-1:0]   nb_col_data,
  output logic                    seq_err
);

  localparam int SW = RES_W + 1;
  typedef logic signed [SW-1:0] sum_t;

  function automatic sum_t add_px(input logic [bitDepth-1:0] p, input logic [RES_W-1:0] r,
                                  input logic byp);
    sum_t pe;
    sum_t re;
    pe = sum_t'({1'b0, p});
    re = byp ? '0 : sum_t'($signed(r));
    return pe + re;
  endfunction

  function automatic logic [bitDepth-1:0] clip_px(input sum_t s, input logic bd10);
    logic [31:0] mx;
    mx = (bd10 ? 32'd1023 : 32'd255) & ((32'd1 << bitDepth) - 32'd1);
    if (s[SW-1]) return '0;
    if (32'(s) > mx) return mx[bitDepth-1:0];
    return s[bitDepth-1:0];
  endfunction

  function automatic logic [2:0] nblk_m1(input logic [1:0] ts);
    case (ts)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [5:0] last_blk_idx(input logic [1:0] ts);
    case (ts)
      2'd0:    return 6'd0;
      2'd1:    return 6'd3;
      2'd2:    return 6'd15;
      default: return 6'd63;
    endcase
  endfunction

  logic [1:0] ts_in;
  logic       can_acc, accept, s2_adv, rec_fire;

  logic                   s1_v_q, s1_v_d;
  sum_t                   s1_sum_q [16];
  sum_t                   s1_sum_d [16];
  logic [2:0]             s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic                   s1_last_q, s1_last_d;
  logic [1:0]             s1_ts_q, s1_ts_d;
  logic                   s1_bd10_q, s1_bd10_d;

  logic                   s2_v_q, s2_v_d;
  logic [bitDepth*16-1:0] s2_pix_q, s2_pix_d;
  logic [2:0]             s2_x_q, s2_x_d, s2_y_q, s2_y_d;
  logic                   s2_last_q, s2_last_d;
  logic [1:0]             s2_ts_q, s2_ts_d;

  logic [5:0]             cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic unused_gp;
  assign unused_gp = ^{gp_bitDepth[3:2], gp_bitDepth[0]};

  assign ts_in = (tuSize > 3'd3) ? 2'd3 : tuSize[1:0];

  // rst gates every handshake so nothing is accepted or emitted in the reset cycle
  assign rec_fire   = s2_v_q & rec_ready & ~bStop & ~rst;
  assign s2_adv     = s1_v_q & (~s2_v_q | rec_fire) & ~bStop & ~rst;
  assign can_acc    = ~rst & ~bStop & (~s1_v_q | s2_adv);
  assign pred_ready = can_acc & (res_bypass | res_valid);
  assign res_ready  = can_acc & pred_valid & ~res_bypass;
  assign accept     = pred_valid & pred_ready;

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_sum_d  = s1_sum_q;
    s1_x_d    = s1_x_q;
    s1_y_d    = s1_y_q;
    s1_last_d = s1_last_q;
    s1_ts_d   = s1_ts_q;
    s1_bd10_d = s1_bd10_q;
    s2_v_d    = s2_v_q;
    s2_pix_d  = s2_pix_q;
    s2_x_d    = s2_x_q;
    s2_y_d    = s2_y_q;
    s2_last_d = s2_last_q;
    s2_ts_d   = s2_ts_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    if (accept) begin
      s1_v_d = 1'b1;
      for (int k = 0; k < 16; k++) begin
        s1_sum_d[k] = add_px(predSamples[(15-k)*bitDepth +: bitDepth],
                             residual[(15-k)*RES_W +: RES_W], res_bypass);
      end
      s1_x_d    = X;
      s1_y_d    = Y;
      s1_last_d = pred_last;
      s1_ts_d   = ts_in;
      s1_bd10_d = gp_bitDepth[1];
    end else if (s2_adv) begin
      s1_v_d = 1'b0;
    end

    if (s2_adv) begin
      s2_v_d = 1'b1;
      for (int k = 0; k < 16; k++) begin
        s2_pix_d[(15-k)*bitDepth +: bitDepth] = clip_px(s1_sum_q[k], s1_bd10_q);
      end
      s2_x_d    = s1_x_q;
      s2_y_d    = s1_y_q;
      s2_last_d = s1_last_q;
      s2_ts_d   = s1_ts_q;
    end else if (rec_fire) begin
      s2_v_d = 1'b0;
    end

    // counter restarts on every last block so one bad TU does not skew the next
    if (accept) begin
      if (pred_last != (cnt_q == last_blk_idx(ts_in))) err_d = 1'b1;
      cnt_d = pred_last ? 6'd0 : cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      for (int k = 0; k < 16; k++) s1_sum_q[k] <= '0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_last_q <= 1'b0;
      s1_ts_q   <= '0;
      s1_bd10_q <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_pix_q  <= '0;
      s2_x_q    <= '0;
      s2_y_q    <= '0;
      s2_last_q <= 1'b0;
      s2_ts_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_sum_q  <= s1_sum_d;
      s1_x_q    <= s1_x_d;
      s1_y_q    <= s1_y_d;
      s1_last_q <= s1_last_d;
      s1_ts_q   <= s1_ts_d;
      s1_bd10_q <= s1_bd10_d;
      s2_v_q    <= s2_v_d;
      s2_pix_q  <= s2_pix_d;
      s2_x_q    <= s2_x_d;
      s2_y_q    <= s2_y_d;
      s2_last_q <= s2_last_d;
      s2_ts_q   <= s2_ts_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign rec_valid   = s2_v_q;
  assign recSamples  = s2_pix_q;
  assign rec_X       = s2_x_q;
  assign rec_Y       = s2_y_q;
  assign rec_last    = s2_last_q;
  assign seq_err     = err_q;
  assign tu_done     = rec_fire & s2_last_q;
  assign nb_row_we   = rec_fire & (s2_y_q == nblk_m1(s2_ts_q));
  assign nb_col_we   = rec_fire & (s2_x_q == nblk_m1(s2_ts_q));
  assign nb_row_idx  = s2_x_q;
  assign nb_col_idx  = s2_y_q;
  assign nb_row_data = s2_pix_q[4*bitDepth-1:0];
  assign nb_col_data = {s2_pix_q[12*bitDepth +: bitDepth], s2_pix_q[8*bitDepth +: bitDepth],
                        s2_pix_q[4*bitDepth +: bitDepth],  s2_pix_q[0 +: bitDepth]};

endmodule
